// File: rtl/piso_stream_pkg.sv
// rtl/piso_stream_pkg.sv - shared sizing helpers for the piso_stream serializer
package piso_stream_pkg;

    function automatic int beats(input int dw, input int lanes);
        return (lanes < 1) ? 1 : dw / lanes;
    endfunction

    function automatic int cnt_w(input int b);
        return (b <= 1) ? 1 : $clog2(b);
    endfunction

endpackage

// File: rtl/piso_stream_if.sv
// rtl/piso_stream_if.sv - word-in / beat-out handshake bundle for piso_stream
interface piso_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_msb_first;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_data;
    logic                  out_first;
    logic                  out_last;
    logic                  busy;

    modport master (
        output in_valid, in_data, in_msb_first, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_msb_first, out_ready,
        output in_ready, out_valid, out_data, out_first, out_last, busy
    );
endinterface

// File: rtl/piso_stream_hold_buf.sv
// rtl/piso_stream_hold_buf.sv - single-entry holding buffer, never overwritten while full
module piso_hold_buf #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ready
);
    assign ready = !valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= push_data;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - ready/valid parallel-in serial-out serializer, LSB- or MSB-first per word
module piso_stream
    import piso_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1
) (
    input  logic         clk,
    input  logic         resetn,
    piso_stream_if.slave bus
);
    localparam int BEATS = beats(DATA_WIDTH, LANES);
    localparam int CNT_W = cnt_w(BEATS);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  msb_first;
    } entry_t;

    generate
        if (LANES < 1 || (DATA_WIDTH % LANES) != 0) begin : g_bad_params
            $error("piso_stream: LANES must be >= 1 and divide DATA_WIDTH");
        end
    endgenerate

    entry_t                in_entry;
    entry_t                hold_data;
    logic                  hold_vld;
    logic                  hold_ready;
    logic                  hold_push;
    logic                  hold_pop;
    logic                  accept;
    logic                  fire;
    logic                  sh_free;
    logic                  sh_vld;
    logic                  sh_msb;
    logic [DATA_WIDTH-1:0] sh_word;
    logic [CNT_W-1:0]      cnt;
    logic [LANES-1:0]      beat;
    logic                  at_last;

    assign in_entry     = '{data: bus.in_data, msb_first: bus.in_msb_first};
    assign bus.in_ready = resetn & hold_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign fire         = sh_vld & bus.out_ready;
    assign at_last      = (cnt == CNT_W'(BEATS - 1));
    assign sh_free      = !sh_vld | (fire & at_last);
    // in_ready implies the buffer is empty, so an accepted word either bypasses or parks
    assign hold_push    = accept & !sh_free;
    assign hold_pop     = sh_free & hold_vld;

    piso_hold_buf #(.W($bits(entry_t))) u_hold (
        .clk       (clk),
        .resetn    (resetn),
        .push      (hold_push),
        .push_data (in_entry),
        .pop       (hold_pop),
        .valid     (hold_vld),
        .data      (hold_data),
        .ready     (hold_ready)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh_vld  <= 1'b0;
            sh_msb  <= 1'b0;
            sh_word <= '0;
            cnt     <= '0;
        end else if (sh_free) begin
            cnt <= '0;
            if (hold_vld) begin
                sh_vld  <= 1'b1;
                sh_word <= hold_data.data;
                sh_msb  <= hold_data.msb_first;
            end else if (accept) begin
                sh_vld  <= 1'b1;
                sh_word <= bus.in_data;
                sh_msb  <= bus.in_msb_first;
            end else begin
                sh_vld <= 1'b0;
            end
        end else if (fire) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Constant part-selects per beat keep the mux free of variable-width index math
    always_comb begin
        beat = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt == CNT_W'(b)) begin
                beat = sh_msb ? sh_word[DATA_WIDTH-1-b*LANES -: LANES]
                              : sh_word[b*LANES +: LANES];
            end
        end
    end

    assign bus.out_valid = sh_vld;
    assign bus.out_data  = sh_vld ? beat : '0;
    assign bus.out_first = sh_vld & (cnt == '0);
    assign bus.out_last  = sh_vld & at_last;
    assign bus.busy      = sh_vld | hold_vld;
endmodule
